// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 8-bit ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win on contention.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [7:0]         req_a0,
    input  logic [7:0]         req_b0,
    input  logic [3:0]         req_sel0,
    input  logic [7:0]         req_a1,
    input  logic [7:0]         req_b1,
    input  logic [3:0]         req_sel1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [7:0]         rsp_out,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_err
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        grant;
    logic        any_valid;
    logic        accept;
    logic [7:0]  a_q, b_q;
    logic [3:0]  sel_q;
    logic        id_q;
    logic [8:0]  sum;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        alu_err;
    logic [7:0]  out_q;
    logic        carry_q, zero_q, err_q, rid_q;

    // Grant selection: lone requester wins, otherwise the one not served last.
    always_comb begin
        any_valid = |req_valid;
        if (&req_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else begin
            grant = req_valid[1];
        end
    end

    assign accept = (state_q == StIdle) && any_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        rsp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant;
            a_q          <= grant ? req_a1   : req_a0;
            b_q          <= grant ? req_b1   : req_b0;
            sel_q        <= grant ? req_sel1 : req_sel0;
            id_q         <= grant;
        end
    end

    // Shared ALU evaluated on the latched operands
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_carry = 1'b0;
        alu_err   = (sel_q > 4'h8);
        case (sel_q)
            4'h0: begin
                alu_out   = sum[7:0];
                alu_carry = sum[8];
            end
            4'h1:    alu_out = a_q - b_q;
            4'h2:    alu_out = a_q & b_q;
            4'h3:    alu_out = a_q | b_q;
            4'h4:    alu_out = a_q ^ b_q;
            4'h5:    alu_out = ~a_q;
            4'h6:    alu_out = {a_q[6:0], 1'b0};
            4'h7:    alu_out = {1'b0, a_q[7:1]};
            4'h8:    alu_out = {7'b0, (a_q < b_q)};
            default: alu_out = '0;
        endcase
    end

    // Response registers load in EXEC and hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            rid_q   <= 1'b0;
        end else if (state_q == StExec) begin
            out_q   <= alu_out;
            carry_q <= alu_carry;
            zero_q  <= (alu_out == 8'h00);
            err_q   <= alu_err;
            rid_q   <= id_q;
        end
    end

    assign rsp_out   = out_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;
    assign rsp_id    = rid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Honours ALU_ARB_FIXED_PRIO_EN for the contention grant order.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0] req_sel0, req_sel1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_err;
    logic [7:0] rsp_out;

    int tests  = 0;
    int failed = 0;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_sel0  (req_sel0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_sel1  (req_sel1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Leaves time at posedge+1 with reset released and inputs idle.
    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one transaction; returns cycles to accept and accept-to-rsp_valid latency.
    // Returns at posedge+2 of the first rsp_valid cycle.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, output int acc, output int lat);
        acc = -1;
        lat = -1;
        if (id == 0) begin
            req_a0 = a; req_b0 = b; req_sel0 = sel;
        end else begin
            req_a1 = a; req_b1 = b; req_sel1 = sel;
        end
        req_valid[id] = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (req_ready[id]) begin
                acc = k;
                break;
            end
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        #1;
        if (acc >= 0) begin
            for (int k = 1; k < 10; k++) begin
                if (rsp_valid) begin
                    lat = k;
                    break;
                end
                @(posedge clk); #2;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        {req_a0, req_b0, req_a1, req_b1} = '0;
        {req_sel0, req_sel1} = '0;
        #3;
        tests++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero, rsp_err} !== 13'b0) begin
            failed++;
            $display("FAIL reset_outputs: got v%b id%b out%h c%b z%b e%b, want all zero",
                     rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero, rsp_err);
        end
        tests++;
        if (req_ready !== 2'b00) begin
            failed++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            failed++;
            $display("FAIL reset_first_prio: got %b want 01", req_ready);
        end
        #1 req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int acc, lat;
        issue(0, 8'd200, 8'd100, 4'h0, acc, lat);
        tests++;
        if (acc !== 0 || lat !== 2) begin
            failed++;
            $display("FAIL single_timing: got acc=%0d lat=%0d want acc=0 lat=2", acc, lat);
        end
        tests++;
        if ({rsp_out, rsp_carry, rsp_zero, rsp_id, rsp_err} !== {8'd44, 4'b1000}) begin
            failed++;
            $display("FAIL single_result: got out%0d c%b z%b id%b e%b want out44 c1 z0 id0 e0",
                     rsp_out, rsp_carry, rsp_zero, rsp_id, rsp_err);
        end
        @(posedge clk); #1;
        // Back-to-back: the next accept lands three cycles after the first
        issue(1, 8'h0F, 8'h01, 4'h6, acc, lat);
        tests++;
        if (acc !== 0 || lat !== 2) begin
            failed++;
            $display("FAIL b2b_timing: got acc=%0d lat=%0d want acc=0 lat=2", acc, lat);
        end
        tests++;
        if ({rsp_out, rsp_id, rsp_carry} !== {8'h1E, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL b2b_result: got out%h id%b c%b want out1e id1 c0",
                     rsp_out, rsp_id, rsp_carry);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int   ng, nr, exp;
        int   cnt [2];
        logic drop [2];
        logic order [6];
        ng = 0; nr = 0;
        cnt[0] = 0; cnt[1] = 0;
        drop[0] = 1'b0; drop[1] = 1'b0;
        apply_reset();
        req_a0 = 8'd5;   req_b0 = 8'd7;   req_sel0 = 4'h1;
        req_a1 = 8'hF0;  req_b1 = 8'h0F;  req_sel1 = 4'h2;
        req_valid = 2'b11;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 6) begin
                order[ng] = req_ready[1];
                ng++;
                cnt[req_ready[1]]++;
                if (cnt[req_ready[1]] == 3) drop[req_ready[1]] = 1'b1;
            end
            if (rsp_valid) begin
                nr++;
                tests++;
                if (rsp_id == 1'b0 && {rsp_out, rsp_carry, rsp_zero} !== {8'hFE, 2'b00}) begin
                    failed++;
                    $display("FAIL cont_r0_result: got out%h c%b z%b want outfe c0 z0",
                             rsp_out, rsp_carry, rsp_zero);
                end else if (rsp_id == 1'b1 &&
                             {rsp_out, rsp_carry, rsp_zero} !== {8'h00, 2'b01}) begin
                    failed++;
                    $display("FAIL cont_r1_result: got out%h c%b z%b want out00 c0 z1",
                             rsp_out, rsp_carry, rsp_zero);
                end
            end
            if (nr == 6) break;
            @(posedge clk); #1;
            if (drop[0]) req_valid[0] = 1'b0;
            if (drop[1]) req_valid[1] = 1'b0;
        end
        tests++;
        if (ng !== 6 || nr !== 6) begin
            failed++;
            $display("FAIL cont_counts: got grants=%0d rsps=%0d want 6 6", ng, nr);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp = (i < 3) ? 0 : 1;
`else
            exp = i % 2;
`endif
            tests++;
            if (order[i] !== exp[0]) begin
                failed++;
                $display("FAIL cont_order[%0d]: got %b want %b", i, order[i], exp[0]);
            end
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_a0 = 8'd1; req_b0 = 8'd2; req_sel0 = 4'h0;
        req_a1 = 8'd9; req_b1 = 8'd1; req_sel1 = 4'h1;
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            failed++;
            $display("FAIL bp_accept: got %b want 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b10;
        #1;
        tests++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL bp_exec: got ready=%b v=%b want ready=00 v=0", req_ready, rsp_valid);
        end
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #2;
            tests++;
            if ({rsp_valid, rsp_out, rsp_id, req_ready} !== {1'b1, 8'd3, 1'b0, 2'b00}) begin
                failed++;
                $display("FAIL bp_hold[%0d]: got v%b out%h id%b ready%b want v1 out03 id0 ready00",
                         i, rsp_valid, rsp_out, rsp_id, req_ready);
            end
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin
            failed++;
            $display("FAIL bp_release: got v%b ready%b want v1 ready00", rsp_valid, req_ready);
        end
        @(posedge clk); #2;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            failed++;
            $display("FAIL bp_next_accept: got v%b ready%b want v0 ready10", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #2;
        tests++;
        if ({rsp_valid, rsp_out, rsp_id} !== {1'b1, 8'd8, 1'b1}) begin
            failed++;
            $display("FAIL bp_r1_result: got v%b out%h id%b want v1 out08 id1",
                     rsp_valid, rsp_out, rsp_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_opcodes();
        // {sel, a, b, out, carry, zero, err}
        logic [30:0] vec [6];
        int acc, lat;
        vec[0] = {4'hA, 8'd3,   8'd4,   8'h00, 1'b0, 1'b1, 1'b1};
        vec[1] = {4'h8, 8'd3,   8'd4,   8'h01, 1'b0, 1'b0, 1'b0};
        vec[2] = {4'h5, 8'h5A,  8'h00,  8'hA5, 1'b0, 1'b0, 1'b0};
        vec[3] = {4'h7, 8'h81,  8'h00,  8'h40, 1'b0, 1'b0, 1'b0};
        vec[4] = {4'h4, 8'hFF,  8'h0F,  8'hF0, 1'b0, 1'b0, 1'b0};
        vec[5] = {4'h8, 8'd9,   8'd2,   8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(0, vec[i][26:19], vec[i][18:11], vec[i][30:27], acc, lat);
            tests++;
            if (lat !== 2 || {rsp_out, rsp_carry, rsp_zero, rsp_err} !== vec[i][10:0]) begin
                failed++;
                $display("FAIL op[%0d]: got lat=%0d out%h c%b z%b e%b want lat=2 out%h c%b z%b e%b",
                         i, lat, rsp_out, rsp_carry, rsp_zero, rsp_err,
                         vec[i][10:3], vec[i][2], vec[i][1], vec[i][0]);
            end
            @(posedge clk); #1;
        end
        // Leave a nonzero response behind for the reset test
        issue(0, 8'd3, 8'd4, 4'h8, acc, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_exec();
        req_a0 = 8'd1; req_b0 = 8'd1; req_sel0 = 4'h0;
        req_valid = 2'b01;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero, rsp_err} !== 13'b0) begin
            failed++;
            $display("FAIL rst_exec_zero: got v%b id%b out%h c%b z%b e%b want all zero",
                     rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero, rsp_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            tests++;
            if (rsp_valid !== 1'b0) begin
                failed++;
                $display("FAIL rst_exec_no_rsp[%0d]: got v%b want v0", i, rsp_valid);
            end
        end
        #1 req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            failed++;
            $display("FAIL rst_exec_prio: got %b want 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #2;
        tests++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_carry} !== {1'b1, 1'b0, 8'd2, 1'b0}) begin
            failed++;
            $display("FAIL rst_exec_after: got v%b id%b out%h c%b want v1 id0 out02 c0",
                     rsp_valid, rsp_id, rsp_out, rsp_carry);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_opcodes();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
